// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed display scan controller.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    SHOW  = 2'd2
  } state_e;

  localparam int MAX_DIG = 8;
  localparam int BCD_W   = 4;

endpackage

// File: rtl/disp_slot_timer.sv
// Slot cycle counter: counts up while enabled, flags the programmed last count,
// and restarts from zero on a synchronous clear.
module disp_slot_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_last,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_last);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment digit scanner with guard/show slots and a double-buffered frame.
// Optional build macro DISP_LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NDIG      = 8,
  parameter int SHOW_CYC  = 1000,
  parameter int GUARD_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    st,
  input  logic                    upd_valid,
  input  logic [NDIG*BCD_W-1:0]   upd_data,
  input  logic [NDIG-1:0]         upd_blank,
  output logic                    upd_ready,
  output logic [BCD_W-1:0]        num,
  output logic [MAX_DIG-1:0]      dig,
  output logic                    frame_done
);

  localparam int CNT_MAX = (SHOW_CYC > GUARD_CYC) ? SHOW_CYC : GUARD_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NDIG);

  state_e                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [NDIG*BCD_W-1:0]   r_act_data;
  logic [NDIG-1:0]         r_act_blank;
  logic [NDIG*BCD_W-1:0]   r_pend_data;
  logic [NDIG-1:0]         r_pend_blank;
  logic                    r_pend_vld;
  logic                    r_upd_ready;
  logic [BCD_W-1:0]        r_num;
  logic [MAX_DIG-1:0]      r_dig;
  logic                    r_frame_done;

  state_e                  w_state_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [NDIG*BCD_W-1:0]   w_act_data_nxt;
  logic [NDIG-1:0]         w_act_blank_nxt;
  logic [NDIG-1:0]         w_blank_eff;
  logic [NDIG-1:0]         w_blank_sh;
  logic                    w_pend_vld_nxt;
  logic                    w_frame_end;
  logic                    w_xfer;
  logic                    w_apply;
  logic                    w_cnt_clr;
  logic [CNT_W-1:0]        w_cnt;
  logic [CNT_W-1:0]        w_cnt_last;
  logic                    w_tc;
  logic [MAX_DIG-1:0]      w_dig_nxt;
  logic [BCD_W-1:0]        w_num_nxt;

  disp_slot_timer #(
    .CNT_W (CNT_W)
  ) u_slot_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_cnt_clr),
    .i_en   (1'b1),
    .i_last (w_cnt_last),
    .o_cnt  (w_cnt),
    .o_tc   (w_tc)
  );

  assign w_cnt_last = (r_state == GUARD) ? CNT_W'(GUARD_CYC - 1) : CNT_W'(SHOW_CYC - 1);
  assign w_cnt_clr  = !st || (r_state == IDLE) || w_tc;
  assign w_xfer     = upd_valid && r_upd_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_frame_end = 1'b0;
    if (!st) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = GUARD;
          w_idx_nxt   = '0;
        end
        GUARD: begin
          if (w_tc) w_state_nxt = SHOW;
        end
        SHOW: begin
          if (w_tc) begin
            w_state_nxt = GUARD;
            if (r_idx == IDX_W'(NDIG - 1)) begin
              w_idx_nxt   = '0;
              w_frame_end = 1'b1;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // Frame buffering: IDLE loads straight into the active frame, otherwise
  // the offer waits in pending until the next frame boundary.
  assign w_apply = w_frame_end && r_pend_vld;

  always_comb begin
    w_act_data_nxt  = r_act_data;
    w_act_blank_nxt = r_act_blank;
    w_pend_vld_nxt  = r_pend_vld;
    if (w_xfer && (r_state == IDLE)) begin
      w_act_data_nxt  = upd_data;
      w_act_blank_nxt = upd_blank;
    end else if (w_apply) begin
      w_act_data_nxt  = r_pend_data;
      w_act_blank_nxt = r_pend_blank;
    end
    if (w_apply) w_pend_vld_nxt = 1'b0;
    if (w_xfer && (r_state != IDLE)) w_pend_vld_nxt = 1'b1;
  end

`ifdef DISP_LEADING_ZERO_BLANK_EN
  function automatic logic [NDIG-1:0] lz_mask(input logic [NDIG*BCD_W-1:0] d);
    logic hi_zero;
    lz_mask = '0;
    hi_zero = 1'b1;
    for (int k = NDIG - 1; k > 0; k--) begin
      hi_zero    = hi_zero && (d[BCD_W*k +: BCD_W] == '0);
      lz_mask[k] = hi_zero;
    end
  endfunction

  assign w_blank_eff = w_act_blank_nxt | lz_mask(w_act_data_nxt);
`else
  assign w_blank_eff = w_act_blank_nxt;
`endif

  // Outputs are precomputed from next-state values so the registered
  // dig/num line up with the state they describe.
  always_comb begin
    w_dig_nxt  = '0;
    w_num_nxt  = '0;
    w_blank_sh = w_blank_eff >> w_idx_nxt;
    if (w_state_nxt != IDLE) begin
      w_num_nxt = w_act_data_nxt[{w_idx_nxt, 2'b00} +: BCD_W];
    end
    if ((w_state_nxt == SHOW) && !w_blank_sh[0]) begin
      w_dig_nxt = MAX_DIG'(1) << w_idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_act_data   <= '0;
      r_act_blank  <= '1;
      r_pend_vld   <= 1'b0;
      r_upd_ready  <= 1'b0;
      r_num        <= '0;
      r_dig        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_act_data   <= w_act_data_nxt;
      r_act_blank  <= w_act_blank_nxt;
      r_pend_vld   <= w_pend_vld_nxt;
      r_upd_ready  <= !w_pend_vld_nxt;
      r_num        <= w_num_nxt;
      r_dig        <= w_dig_nxt;
      r_frame_done <= w_frame_end;
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer && (r_state != IDLE)) begin
      r_pend_data  <= upd_data;
      r_pend_blank <= upd_blank;
    end
  end

  assign upd_ready  = r_upd_ready;
  assign num        = r_num;
  assign dig        = r_dig;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with NDIG=4, SHOW_CYC=4, GUARD_CYC=2.
module tb_disp_scan_ctrl;

  localparam int NDIG      = 4;
  localparam int SHOW_CYC  = 4;
  localparam int GUARD_CYC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_data = '0;
  logic [3:0]  upd_blank = '0;
  logic        upd_ready;
  logic [3:0]  num;
  logic [7:0]  dig;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          n;
    logic        s;
    logic        uv;
    logic [15:0] d;
    logic [3:0]  b;
    logic [7:0]  dg;
    logic [3:0]  nm;
    logic        fd;
    logic        rd;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  disp_scan_ctrl #(
    .NDIG      (NDIG),
    .SHOW_CYC  (SHOW_CYC),
    .GUARD_CYC (GUARD_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .st         (st),
    .upd_valid  (upd_valid),
    .upd_data   (upd_data),
    .upd_blank  (upd_blank),
    .upd_ready  (upd_ready),
    .num        (num),
    .dig        (dig),
    .frame_done (frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int n, input logic s, input logic uv, input logic [15:0] d,
                     input logic [3:0] b, input logic [7:0] dg, input logic [3:0] nm,
                     input logic fd, input logic rd);
    vec_t v;
    v.n = n; v.s = s; v.uv = uv; v.d = d; v.b = b;
    v.dg = dg; v.nm = nm; v.fd = fd; v.rd = rd;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] D1;
    logic [15:0] D2;
    logic [7:0]  seen;
    logic [7:0]  exp_dg [4];
    logic [3:0]  exp_nm [4];
    D1 = 16'h4321;
    D2 = 16'h8765;

    // IDLE load, then frame 1 showing 1,2,3,4
    add(1, 0, 1, D1, 4'b0000, 8'h00, 0, 0, 1);
    add(2, 1, 0, D1, 4'b0000, 8'h00, 1, 0, 1);
    add(4, 1, 0, D1, 4'b0000, 8'h01, 1, 0, 1);
    add(2, 1, 0, D1, 4'b0000, 8'h00, 2, 0, 1);
    add(4, 1, 0, D1, 4'b0000, 8'h02, 2, 0, 1);
    add(2, 1, 0, D1, 4'b0000, 8'h00, 3, 0, 1);
    add(4, 1, 0, D1, 4'b0000, 8'h04, 3, 0, 1);
    add(2, 1, 0, D1, 4'b0000, 8'h00, 4, 0, 1);
    add(4, 1, 0, D1, 4'b0000, 8'h08, 4, 0, 1);
    // frame 2: mid-frame offer of 8765 goes to pending
    add(1, 1, 0, D1, 4'b0000, 8'h00, 1, 1, 1);
    add(1, 1, 0, D1, 4'b0000, 8'h00, 1, 0, 1);
    add(1, 1, 0, D1, 4'b0000, 8'h01, 1, 0, 1);
    add(1, 1, 1, D2, 4'b0000, 8'h01, 1, 0, 0);
    add(2, 1, 0, D2, 4'b0000, 8'h01, 1, 0, 0);
    add(2, 1, 0, D2, 4'b0000, 8'h00, 2, 0, 0);
    add(4, 1, 0, D2, 4'b0000, 8'h02, 2, 0, 0);
    add(2, 1, 0, D2, 4'b0000, 8'h00, 3, 0, 0);
    add(4, 1, 0, D2, 4'b0000, 8'h04, 3, 0, 0);
    add(2, 1, 0, D2, 4'b0000, 8'h00, 4, 0, 0);
    add(4, 1, 0, D2, 4'b0000, 8'h08, 4, 0, 0);
    // frame 3: 5,6,7,8 applied; offer blank=0100 right away
    add(1, 1, 0, D2, 4'b0000, 8'h00, 5, 1, 1);
    add(1, 1, 1, D2, 4'b0100, 8'h00, 5, 0, 0);
    add(4, 1, 0, D2, 4'b0100, 8'h01, 5, 0, 0);
    add(2, 1, 0, D2, 4'b0100, 8'h00, 6, 0, 0);
    add(4, 1, 0, D2, 4'b0100, 8'h02, 6, 0, 0);
    add(2, 1, 0, D2, 4'b0100, 8'h00, 7, 0, 0);
    add(4, 1, 0, D2, 4'b0100, 8'h04, 7, 0, 0);
    add(2, 1, 0, D2, 4'b0100, 8'h00, 8, 0, 0);
    add(4, 1, 0, D2, 4'b0100, 8'h08, 8, 0, 0);
    // frame 4: digit 2 blanked; unblanked frame offered for frame 5
    add(1, 1, 0, D2, 4'b0000, 8'h00, 5, 1, 1);
    add(1, 1, 1, D2, 4'b0000, 8'h00, 5, 0, 0);
    add(4, 1, 0, D2, 4'b0000, 8'h01, 5, 0, 0);
    add(2, 1, 0, D2, 4'b0000, 8'h00, 6, 0, 0);
    add(4, 1, 0, D2, 4'b0000, 8'h02, 6, 0, 0);
    add(2, 1, 0, D2, 4'b0000, 8'h00, 7, 0, 0);
    add(4, 1, 0, D2, 4'b0000, 8'h00, 7, 0, 0);
    add(2, 1, 0, D2, 4'b0000, 8'h00, 8, 0, 0);
    add(4, 1, 0, D2, 4'b0000, 8'h08, 8, 0, 0);
    add(1, 1, 0, D2, 4'b0000, 8'h00, 5, 1, 1);

    // reset state
    repeat (3) tick;
    chk("rst_dig", 32'(dig), 32'h0);
    chk("rst_num", 32'(num), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_ready", 32'(upd_ready), 32'h0);
    rst = 1'b1;
    tick;
    chk("post_rst_ready", 32'(upd_ready), 32'h1);
    chk("post_rst_dig", 32'(dig), 32'h0);

    foreach (tbl[r]) begin
      st        = tbl[r].s;
      upd_valid = tbl[r].uv;
      upd_data  = tbl[r].d;
      upd_blank = tbl[r].b;
      for (int c = 0; c < tbl[r].n; c++) begin
        tick;
        chk($sformatf("row%0d.%0d {dig,num,fd,rdy}", r, c),
            32'({dig, num, frame_done, upd_ready}),
            32'({tbl[r].dg, tbl[r].nm, tbl[r].fd, tbl[r].rd}));
      end
    end
    upd_valid = 1'b0;

    // st dropped during SHOW of digit 2, then re-raised
    for (int i = 0; i < 40 && dig !== 8'h04; i++) tick;
    chk("t4_reach_d2", 32'(dig), 32'h04);
    chk("t4_d2_num", 32'(num), 32'h7);
    st = 1'b0;
    tick;
    chk("t4_stop_dig", 32'(dig), 32'h0);
    chk("t4_stop_num", 32'(num), 32'h0);
    st = 1'b1;
    tick;
    chk("t4_restart_g0", 32'({dig, num}), 32'({8'h00, 4'h5}));
    tick;
    chk("t4_restart_g1", 32'({dig, num}), 32'({8'h00, 4'h5}));
    tick;
    chk("t4_restart_show", 32'({dig, num}), 32'({8'h01, 4'h5}));

    // asynchronous reset mid-SHOW
    for (int i = 0; i < 40 && dig === 8'h00; i++) tick;
    chk("t5_lit_before_rst", 32'(dig != 8'h00), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_dig", 32'(dig), 32'h0);
    chk("t5_async_num", 32'(num), 32'h0);
    chk("t5_async_ready", 32'(upd_ready), 32'h0);
    @(posedge clk);
    #3;
    chk("t5_held_ready", 32'(upd_ready), 32'h0);
    rst = 1'b1;
    tick;
    chk("t5_release_ready", 32'(upd_ready), 32'h1);
    seen = '0;
    for (int i = 0; i < 30; i++) begin
      tick;
      seen = seen | dig;
    end
    chk("t5_dark_scan", 32'(seen), 32'h0);

    // 0x0050 frame, with and without leading-zero suppression
    st = 1'b0;
    tick;
    upd_valid = 1'b1;
    upd_data  = 16'h0050;
    upd_blank = 4'b0000;
    tick;
    upd_valid = 1'b0;
    chk("t6_idle_load_ready", 32'(upd_ready), 32'h1);
    exp_nm[0] = 4'h0; exp_nm[1] = 4'h5; exp_nm[2] = 4'h0; exp_nm[3] = 4'h0;
`ifdef DISP_LEADING_ZERO_BLANK_EN
    exp_dg[0] = 8'h01; exp_dg[1] = 8'h02; exp_dg[2] = 8'h00; exp_dg[3] = 8'h00;
`else
    exp_dg[0] = 8'h01; exp_dg[1] = 8'h02; exp_dg[2] = 8'h04; exp_dg[3] = 8'h08;
`endif
    st = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < GUARD_CYC; c++) begin
        tick;
        chk($sformatf("t6_guard%0d.%0d", k, c), 32'({dig, num}), 32'({8'h00, exp_nm[k]}));
      end
      for (int c = 0; c < SHOW_CYC; c++) begin
        tick;
        chk($sformatf("t6_show%0d.%0d", k, c), 32'({dig, num}), 32'({exp_dg[k], exp_nm[k]}));
      end
    end
    tick;
    chk("t6_frame_done", 32'(frame_done), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter NDIG, default 8: number of multiplexed digits, range 2..8.
REQ-002 Parameter SHOW_CYC, default 1000: clk cycles per digit with its select driven, at least 1.
REQ-003 Parameter GUARD_CYC, default 16: clk cycles of all-off guard before each digit, at least 1.
REQ-004 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous assert, active-low (0 = reset).
REQ-006 Port st, input, 1: scan enable; 0 forces idle/blank.
REQ-007 Port upd_valid, input, 1: new digit frame offered.
REQ-008 Port upd_data, input, NDIG*4: nibble k (bits 4k+3:4k) = BCD value of digit k; digit 0 is rightmost.
REQ-009 Port upd_blank, input, NDIG: bit k=1 blanks digit k.
REQ-010 Port upd_ready, output, 1: controller can accept a frame.
REQ-011 Port num, output, 4: BCD value for the downstream segment decoder.
REQ-012 Port dig, output, 8: one-hot active-high digit select; bits NDIG..7 are always 0.
REQ-013 Port frame_done, output, 1: one-cycle pulse at the end of each full scan.

Function
REQ-014 FSM states: IDLE, GUARD, SHOW. Registers: idx (digit index), cnt (cycle counter), active frame, pending frame, pend_vld.
REQ-015 IDLE: dig=0, num=0; when st=1, next state GUARD with idx=0, cnt=0.
REQ-016 GUARD: dig=0, num=active nibble[idx]; cnt increments; at cnt==GUARD_CYC-1, next state SHOW with cnt=0.
REQ-017 SHOW: dig=(1<<idx) unless active blank[idx]=1, then dig=0; num=active nibble[idx]; at cnt==SHOW_CYC-1, next state GUARD with cnt=0 and idx=idx+1, wrapping NDIG-1 to 0.
REQ-018 On the SHOW to GUARD transition with idx==NDIG-1: frame_done=1 for that one cycle, and if pend_vld=1, active<=pending and pend_vld<=0 in the same cycle.
REQ-019 Per-digit period is exactly GUARD_CYC+SHOW_CYC cycles; frame period is NDIG times that.
REQ-020 st=0 in any state: next state IDLE, idx and cnt cleared, no frame_done pulse.
REQ-021 Handshake: upd_ready = !pend_vld; transfer occurs when upd_valid && upd_ready, capturing upd_data and upd_blank into pending and setting pend_vld.
REQ-022 In IDLE, a transfer writes directly to active; pend_vld stays 0.
REQ-023 A transfer in the same cycle as a frame-end apply is captured into pending and applied at the next frame end; nothing is lost.
REQ-024 Nibble values above 9 pass through unchanged on num; decoding is downstream.
REQ-025 All outputs are registered; dig and num change only on clk edges, with no combinational path from inputs.

Reset
REQ-026 While rst=0: state=IDLE, idx=0, cnt=0, dig=0, num=0, frame_done=0, pend_vld=0, upd_ready=0.
REQ-027 Active frame resets to data 0 and blank all-ones, so every digit is blank.
REQ-028 The first cycle after rst deasserts, upd_ready=1.
REQ-029 Reset mid-scan takes effect immediately and asynchronously; outputs are dark with no partial digit.

Configuration
REQ-030 Macro DISP_LEADING_ZERO_BLANK_EN, when defined: digit k is additionally blanked when its nibble and all higher nibbles are 0, with k>0; digit 0 is never suppressed.
REQ-031 Without the macro: blanking comes only from upd_blank.

Structure
REQ-032 Package disp_pkg holds the state enum (IDLE/GUARD/SHOW), the MAX_DIG=8 constant and the BCD_W=4 constant.
REQ-033 One sub-module, disp_slot_timer: a cnt counter with a terminal-count output and a synchronous clear, instantiated once.

Verification (NDIG=4, SHOW_CYC=4, GUARD_CYC=2)
REQ-034 Test 1: reset, load 0x4321 with blank 0000, st=1 -> dig sequence 0,0,0001x4,0,0,0010x4,0,0,0100x4,0,0,1000x4 with num 1,2,3,4; frame_done pulses after 24 cycles.
REQ-035 Test 2: mid-frame transfer of 0x8765 -> upd_ready falls to 0; current frame still shows 4321; the next frame shows 5,6,7,8; upd_ready returns to 1 at frame end.
REQ-036 Test 3: blank=0100 -> the digit 2 slot keeps dig=0 for its 4 SHOW cycles, and slot timing is unchanged.
REQ-037 Test 4: st dropped during SHOW of digit 2 -> dig=0 next cycle; st re-raised -> scan restarts at digit 0 after 2 guard cycles.
REQ-038 Test 5: rst asserted mid-SHOW -> dig=0 and num=0 without waiting for clk; after release, scan is dark until the first transfer.
REQ-039 Test 6: with DISP_LEADING_ZERO_BLANK_EN, data 0x0050 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0.
